// File: rtl/imem_prog_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
// The memory geometry and the frame/pad byte values are also used by the
// processor's inst_mem, so they live here rather than in the loader itself.
package imem_prog_loader_pkg;

  localparam int IMEM_ADDR_W = 4;
  localparam int IMEM_DATA_W = 8;

  localparam logic [IMEM_DATA_W-1:0] DEF_SYNC_BYTE = 8'hA5;
  localparam logic [IMEM_DATA_W-1:0] DEF_HALT_WORD = 8'hFF;

  // Loader sequencing: wait for sync, read length, stream instructions,
  // compare checksum, optionally pad with halts, then run.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    FILL = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

// File: rtl/imem_prog_loader.sv
// Instruction-memory program loader.
// Accepts a framed program (SYNC, LEN, LEN instruction bytes, XOR checksum)
// on a valid/ready byte stream, writes it into inst_mem through a registered
// write port, and holds the processor in reset until a frame checks out.
// Build option: define IMEM_PROG_LOADER_HALT_PAD_EN to pad the unwritten tail
// of the memory with HALT_WORD after a good short frame.
module imem_prog_loader
  import imem_prog_loader_pkg::*;
#(
  parameter int                ADDR_W    = IMEM_ADDR_W,
  parameter int                DATA_W    = IMEM_DATA_W,
  parameter logic [DATA_W-1:0] SYNC_BYTE = DEF_SYNC_BYTE,
  parameter logic [DATA_W-1:0] HALT_WORD = DEF_HALT_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  // Depth expressed at the byte width (for the LEN range check) and at the
  // address-counter width (which is one bit wider so it can hold DEPTH).
  localparam logic [DATA_W-1:0] DEPTH_B = DATA_W'(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W + 1)'(DEPTH);

  state_t state, state_next;

  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   addr;
  logic [DATA_W-1:0] csum;

  logic              we_q;
  logic              xfer;
  logic              we_next;
  logic [DATA_W-1:0] wdata_next;
  logic              err_set;
  logic              err_clr;
  logic              len_load;
  logic              data_step;
  logic              fill_step;

  // The loader stalls the stream only while padding; ready also drops while
  // rst is held so nothing is consumed during reset.
  assign in_ready = rst & (state != FILL);
  assign xfer     = in_valid & in_ready;

  // A write pulse already in flight is suppressed as soon as rst is asserted,
  // so a reset mid-frame never lets one more byte reach inst_mem.
  assign imem_we  = we_q & rst;

  // Next-state and per-cycle actions of the frame sequencer.
  always_comb begin
    state_next = state;
    we_next    = 1'b0;
    wdata_next = in_data;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    len_load   = 1'b0;
    data_step  = 1'b0;
    fill_step  = 1'b0;
    case (state)
      IDLE: begin
        if (xfer && (in_data == SYNC_BYTE)) begin
          err_clr    = 1'b1;
          state_next = LEN;
        end
      end
      LEN: begin
        if (xfer) begin
          if ((in_data == '0) || (in_data > DEPTH_B)) begin
            err_set    = 1'b1;
            state_next = IDLE;
          end else begin
            len_load   = 1'b1;
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          we_next   = 1'b1;
          data_step = 1'b1;
          // addr holds the index of the byte being accepted now.
          if ((addr + 1'b1) == count) begin
            state_next = CSUM;
          end
        end
      end
      CSUM: begin
        if (xfer) begin
          if (in_data == csum) begin
`ifdef IMEM_PROG_LOADER_HALT_PAD_EN
            if (count < DEPTH_A) begin
              state_next = FILL;
            end else begin
              state_next = DONE;
            end
`else
            state_next = DONE;
`endif
          end else begin
            err_set    = 1'b1;
            state_next = IDLE;
          end
        end
      end
      FILL: begin
        // One halt word per cycle from LEN up to the last address.
        we_next    = 1'b1;
        wdata_next = HALT_WORD;
        fill_step  = 1'b1;
        if (addr == (DEPTH_A - 1'b1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (xfer && (in_data == SYNC_BYTE)) begin
          state_next = LEN;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control registers and the registered inst_mem write port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cpu_rst    <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      we_q       <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
    end else begin
      state     <= state_next;
      // The processor runs only while the loader sits in DONE; leaving DONE
      // on a new sync byte re-asserts its reset on the same edge.
      cpu_rst   <= (state_next != DONE);
      load_done <= (state_next == DONE);
      if (err_set) begin
        load_err <= 1'b1;
      end else if (err_clr) begin
        load_err <= 1'b0;
      end
      we_q <= we_next;
      if (we_next) begin
        imem_waddr <= addr[ADDR_W-1:0];
        imem_wdata <= wdata_next;
      end
    end
  end

  // Frame datapath: byte counter, write address and running XOR checksum.
  // These are always re-initialised by the LEN byte before use.
  always_ff @(posedge clk) begin
    if (len_load) begin
      count <= in_data[ADDR_W:0];
      addr  <= '0;
      csum  <= '0;
    end else if (data_step) begin
      addr  <= addr + 1'b1;
      csum  <= csum ^ in_data;
    end else if (fill_step) begin
      addr  <= addr + 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_prog_loader.sv
// Directed bench for imem_prog_loader (default build, halt padding disabled).
// Each inst_mem write is logged as {addr, data} and compared with hand-made
// expectations after each frame.
module tb_imem_prog_loader;
  import imem_prog_loader_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       imem_we;
  logic [3:0] imem_waddr;
  logic [7:0] imem_wdata;
  logic       cpu_rst;
  logic       load_done;
  logic       load_err;

  int n_chk = 0;
  int n_pass = 0;
  logic [11:0] wlog[$];

  imem_prog_loader dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  // Record each write pulse midway through its cycle.
  always @(negedge clk) begin
    if (imem_we) wlog.push_back({imem_waddr, imem_wdata});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Present one byte for one cycle; inputs change 1ns after the rising edge.
  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cpu_rst"},   32'(cpu_rst),    32'd1);
    chk({tag, "_done"},      32'(load_done),  32'd0);
    chk({tag, "_err"},       32'(load_err),   32'd0);
    chk({tag, "_we"},        32'(imem_we),    32'd0);
    chk({tag, "_waddr"},     32'(imem_waddr), 32'd0);
    chk({tag, "_wdata"},     32'(imem_wdata), 32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),   32'd0);
  endtask

  initial begin
    logic [7:0] b;

    // Reset state
    idle(3);
    chk_reset_vals("rst");
    rst = 1'b1;
    #1;
    chk("rst_rel_ready", 32'(in_ready), 32'd1);

    // Good 3-byte load
    wlog.delete();
    send(8'hA5); send(8'h03); send(8'h00); send(8'h11); send(8'h22);
    chk("t1_rst_held", 32'(cpu_rst), 32'd1);
    chk("t1_done_low", 32'(load_done), 32'd0);
    send(8'h33);
    chk("t1_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("t1_done", 32'(load_done), 32'd1);
    chk("t1_err", 32'(load_err), 32'd0);
    chk("t1_nwr", 32'(wlog.size()), 32'd3);
    chk("t1_wr0", 32'(wlog[0]), 32'h000);
    chk("t1_wr1", 32'(wlog[1]), 32'h111);
    chk("t1_wr2", 32'(wlog[2]), 32'h222);
    idle(1);
    chk("t1_we_idle", 32'(imem_we), 32'd0);

    // Bad checksum (reload from DONE)
    wlog.delete();
    send(8'hA5);
    chk("t2_reload_rst", 32'(cpu_rst), 32'd1);
    chk("t2_reload_done", 32'(load_done), 32'd0);
    send(8'h02); send(8'h50); send(8'h61); send(8'h00);
    chk("t2_err", 32'(load_err), 32'd1);
    chk("t2_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("t2_done", 32'(load_done), 32'd0);
    chk("t2_nwr", 32'(wlog.size()), 32'd2);
    chk("t2_wr0", 32'(wlog[0]), 32'h050);
    chk("t2_wr1", 32'(wlog[1]), 32'h161);

    // Illegal lengths 0 and 17
    wlog.delete();
    send(8'hA5);
    chk("t3_err_clr", 32'(load_err), 32'd0);
    send(8'h00);
    chk("t3_len0_err", 32'(load_err), 32'd1);
    send(8'hA5);
    chk("t3_err_clr2", 32'(load_err), 32'd0);
    send(8'h11);
    chk("t3_len17_err", 32'(load_err), 32'd1);
    chk("t3_nwr", 32'(wlog.size()), 32'd0);
    chk("t3_cpu_rst", 32'(cpu_rst), 32'd1);

    // Garbage in IDLE, then 1-byte load, then reload request
    wlog.delete();
    send(8'h3C);
    chk("t4_garbage_err", 32'(load_err), 32'd1);
    send(8'hA5); send(8'h01); send(8'h80); send(8'h80);
    chk("t4_done", 32'(load_done), 32'd1);
    chk("t4_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("t4_err", 32'(load_err), 32'd0);
    chk("t4_nwr", 32'(wlog.size()), 32'd1);
    chk("t4_wr0", 32'(wlog[0]), 32'h080);
    send(8'h3C);
    chk("t4_ignore_in_done", 32'(cpu_rst), 32'd0);
    send(8'hA5);
    chk("t4_reload_rst", 32'(cpu_rst), 32'd1);
    chk("t4_reload_done", 32'(load_done), 32'd0);

    // Full-depth frame with gaps, reset after 7 data bytes
    wlog.delete();
    send(8'h10);
    for (int i = 0; i < 7; i++) begin
      send(8'h10 + 8'(i));
      idle(1);
    end
    rst = 1'b0;
    for (int i = 7; i < 10; i++) begin
      send(8'h10 + 8'(i));
      idle(1);
    end
    chk_reset_vals("t5");
    chk("t5_nwr", 32'(wlog.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("t5_wr%0d", i), 32'(wlog[i]), 32'({4'(i), 8'h10 + 8'(i)}));
    end

    // Recovery with a maximum-length (16-byte) frame
    rst = 1'b1;
    idle(1);
    wlog.delete();
    send(8'hA5); send(8'h10);
    for (int i = 0; i < 16; i++) begin
      b = 8'(i * 17);
      send(b);
    end
    send(8'h00);
    chk("t6_done", 32'(load_done), 32'd1);
    chk("t6_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("t6_err", 32'(load_err), 32'd0);
    chk("t6_ready", 32'(in_ready), 32'd1);
    chk("t6_nwr", 32'(wlog.size()), 32'd16);
    chk("t6_wr0", 32'(wlog[0]), 32'h000);
    chk("t6_wr9", 32'(wlog[9]), 32'h999);
    chk("t6_wr15", 32'(wlog[15]), 32'hFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
